iob_dbus_split: RTL and testbench

Address-decoding splitter between the VexRiscv wrapper's packed IOb data bus and up to four IOb slaves (internal SRAM, boot ROM, peripherals, external memory). Routes each request to the slave chosen by the top address bits. Counts outstanding reads and steers each `rvalid`/`rdata` back from the correct slave. Stalls the master whenever accepting a read would let responses return out of order or overflow the pending counter.

---
 rtl/iob_dbus_split_pkg.sv | 26 ++
 rtl/iob_dbus_split_ctrl.sv | 91 +++++++++
 rtl/iob_reg_re.sv | 24 ++
 rtl/iob_dbus_split.sv | 114 +++++++++++
 tb/tb_iob_dbus_split.sv | 267 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/iob_dbus_split_pkg.sv
// Shared widths, response field positions and request classification for the
// IOb data-bus splitter.
package iob_dbus_split_pkg;

  localparam int RESP_READY_POS  = 0;
  localparam int RESP_RVALID_POS = 1;
  localparam int RESP_RDATA_LSB  = 2;

  typedef enum logic [1:0] {
    REQ_IDLE,
    REQ_WRITE,
    REQ_READ,
    REQ_BAD
  } req_kind_e;

  // Request word is {avalid, addr, wdata, wstrb}
  function automatic int req_w(input int addr_w, input int data_w);
    return 1 + addr_w + data_w + data_w / 8;
  endfunction

  // Response word is {rdata, rvalid, ready}
  function automatic int resp_w(input int data_w);
    return data_w + 2;
  endfunction

endpackage

// File: rtl/iob_dbus_split_ctrl.sv
// Outstanding-read tracking for the splitter: pending counter, owning slave,
// read blocking and the sticky protocol-error flag.
module iob_dbus_split_ctrl
  import iob_dbus_split_pkg::*;
#(
  parameter int N_SLAVES = 2,
  parameter int SEL_W    = 1,
  parameter int MAX_PEND = 4,
  parameter int PEND_W   = $clog2(MAX_PEND + 1)
) (
  input  logic                clk_i,
  input  logic                cke_i,
  input  logic                rst_i,
  input  logic                rd_req,
  input  logic                rd_acc,
  input  logic                bad_req,
  input  logic [SEL_W-1:0]    sel,
  input  logic [N_SLAVES-1:0] s_rvalid,
  output logic                blocked,
  output logic                fwd_rvalid,
  output logic [SEL_W-1:0]    pend_sel,
  output logic [PEND_W-1:0]   pend,
  output logic                err
);

  logic [PEND_W-1:0]   pend_reg, pend_next;
  logic [SEL_W-1:0]    pend_sel_reg;
  logic                err_reg, err_next;
  logic [N_SLAVES-1:0] expect_rv;
  logic                any_pend, full, last_rsp, stray;

  assign any_pend = (pend_reg != '0);
  assign full     = (pend_reg == PEND_W'(MAX_PEND));

  // Only the owning slave may legally raise rvalid while reads are pending
  for (genvar gi = 0; gi < N_SLAVES; gi++) begin : g_expect
    assign expect_rv[gi] = any_pend && (pend_sel_reg == SEL_W'(gi));
  end

  assign fwd_rvalid = |(s_rvalid & expect_rv);
  assign stray      = |(s_rvalid & ~expect_rv);
  assign last_rsp   = fwd_rvalid && (pend_reg == PEND_W'(1));

  // A response retiring in this cycle frees the slot (or the ownership) at once
  assign blocked = rd_req &&
                   ((full && !fwd_rvalid) ||
                    (any_pend && (sel != pend_sel_reg) && !last_rsp));

  always_comb begin
    pend_next = pend_reg;
    if (rd_acc && !fwd_rvalid && !full) begin
      pend_next = pend_reg + PEND_W'(1);
    end else if (!rd_acc && fwd_rvalid) begin
      pend_next = pend_reg - PEND_W'(1);
    end
  end

  assign err_next = err_reg || stray || bad_req;

  iob_reg_re #(.DATA_W(PEND_W), .RST_VAL('0)) u_pend_reg (
    .clk_i  (clk_i),
    .cke_i  (cke_i),
    .rst_i  (rst_i),
    .en_i   (1'b1),
    .data_i (pend_next),
    .data_o (pend_reg)
  );

  iob_reg_re #(.DATA_W(SEL_W), .RST_VAL('0)) u_pend_sel_reg (
    .clk_i  (clk_i),
    .cke_i  (cke_i),
    .rst_i  (rst_i),
    .en_i   (rd_acc),
    .data_i (sel),
    .data_o (pend_sel_reg)
  );

  iob_reg_re #(.DATA_W(1), .RST_VAL(1'b0)) u_err_reg (
    .clk_i  (clk_i),
    .cke_i  (cke_i),
    .rst_i  (rst_i),
    .en_i   (1'b1),
    .data_i (err_next),
    .data_o (err_reg)
  );

  assign pend_sel = pend_sel_reg;
  assign pend     = pend_reg;
  assign err      = err_reg;

endmodule

// File: rtl/iob_reg_re.sv
// Register with clock enable, synchronous active-high reset and load enable.
module iob_reg_re #(
  parameter int                DATA_W  = 1,
  parameter logic [DATA_W-1:0] RST_VAL = '0
) (
  input  logic              clk_i,
  input  logic              cke_i,
  input  logic              rst_i,
  input  logic              en_i,
  input  logic [DATA_W-1:0] data_i,
  output logic [DATA_W-1:0] data_o
);

  always_ff @(posedge clk_i) begin
    if (cke_i) begin
      if (rst_i) begin
        data_o <= RST_VAL;
      end else if (en_i) begin
        data_o <= data_i;
      end
    end
  end

endmodule

// File: rtl/iob_dbus_split.sv
// Address-decoding splitter from one IOb master to N_SLAVES IOb slaves, with
// in-order read response steering.
module iob_dbus_split
  import iob_dbus_split_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int N_SLAVES = 2,
  parameter int SEL_W    = $clog2(N_SLAVES),
  parameter int MAX_PEND = 4,
  localparam int REQ_W   = req_w(ADDR_W, DATA_W),
  localparam int RESP_W  = resp_w(DATA_W),
  localparam int PEND_W  = $clog2(MAX_PEND + 1)
) (
  input  logic                       clk_i,
  input  logic                       cke_i,
  input  logic                       rst_i,
  input  logic [REQ_W-1:0]           m_req_i,
  output logic [RESP_W-1:0]          m_resp_o,
  output logic [N_SLAVES*REQ_W-1:0]  s_req_o,
  input  logic [N_SLAVES*RESP_W-1:0] s_resp_i,
  output logic [PEND_W-1:0]          pend_o,
  output logic                       err_o
);

  logic                avalid;
  logic [ADDR_W-1:0]   addr;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic [SEL_W-1:0]    sel, pend_sel;
  logic                sel_ok, sel_ready, blocked, fwd_rvalid, m_ready, rd_acc;
  req_kind_e           kind;
  logic [N_SLAVES-1:0] s_ready, s_rvalid, s_avalid;
  logic [DATA_W-1:0]   s_rdata [N_SLAVES];
  logic [DATA_W-1:0]   m_rdata;

  assign {avalid, addr, wdata, wstrb} = m_req_i;
  assign sel    = addr[ADDR_W-1 -: SEL_W];
  assign sel_ok = (int'(sel) < N_SLAVES);

  always_comb begin
    kind = REQ_IDLE;
    if (avalid) begin
      if (!sel_ok) begin
        kind = REQ_BAD;
      end else if (wstrb == '0) begin
        kind = REQ_READ;
      end else begin
        kind = REQ_WRITE;
      end
    end
  end

  // Payload is broadcast; only the selected, unblocked slave sees avalid
  for (genvar gi = 0; gi < N_SLAVES; gi++) begin : g_slave
    assign s_ready[gi]  = s_resp_i[gi*RESP_W + RESP_READY_POS];
    assign s_rvalid[gi] = s_resp_i[gi*RESP_W + RESP_RVALID_POS];
    assign s_rdata[gi]  = s_resp_i[gi*RESP_W + RESP_RDATA_LSB +: DATA_W];
    assign s_avalid[gi] = ((kind == REQ_READ) || (kind == REQ_WRITE)) &&
                          (sel == SEL_W'(gi)) && !blocked;
    assign s_req_o[gi*REQ_W +: REQ_W] = {s_avalid[gi], addr, wdata, wstrb};
  end

  always_comb begin
    sel_ready = 1'b0;
    for (int k = 0; k < N_SLAVES; k++) begin
      if (sel == SEL_W'(k)) sel_ready = s_ready[k];
    end
  end

  always_comb begin
    m_rdata = '0;
    for (int k = 0; k < N_SLAVES; k++) begin
      if (pend_sel == SEL_W'(k)) m_rdata = s_rdata[k];
    end
  end

  always_comb begin
    m_ready = sel_ready;
    if (kind == REQ_BAD) begin
      m_ready = 1'b1;
    end else if (blocked) begin
      m_ready = 1'b0;
    end
  end

  assign rd_acc = (kind == REQ_READ) && sel_ready && !blocked;

  iob_dbus_split_ctrl #(
    .N_SLAVES (N_SLAVES),
    .SEL_W    (SEL_W),
    .MAX_PEND (MAX_PEND),
    .PEND_W   (PEND_W)
  ) u_ctrl (
    .clk_i      (clk_i),
    .cke_i      (cke_i),
    .rst_i      (rst_i),
    .rd_req     (kind == REQ_READ),
    .rd_acc     (rd_acc),
    .bad_req    (kind == REQ_BAD),
    .sel        (sel),
    .s_rvalid   (s_rvalid),
    .blocked    (blocked),
    .fwd_rvalid (fwd_rvalid),
    .pend_sel   (pend_sel),
    .pend       (pend_o),
    .err        (err_o)
  );

  assign m_resp_o[RESP_READY_POS]                  = m_ready;
  assign m_resp_o[RESP_RVALID_POS]                 = fwd_rvalid;
  assign m_resp_o[RESP_RDATA_LSB +: DATA_W]        = m_rdata;

endmodule

// File: tb/tb_iob_dbus_split.sv
// Self-checking bench for iob_dbus_split: cycle vector table, reset/clock-enable
// sequences and a randomised read scoreboard against a latency slave model.
module tb_iob_dbus_split;

  localparam int REQ_W  = 69;
  localparam int RESP_W = 34;
  localparam logic [31:0] KEY = 32'hA5A5_0F0F;

  logic              clk = 1'b0;
  logic              cke, rst;
  logic              avalid;
  logic [31:0]       addr, wdata;
  logic [3:0]        wstrb;
  logic [1:0]        rdy, rv;
  logic [31:0]       rd [2];
  logic [REQ_W-1:0]  m_req;
  logic [RESP_W-1:0] m_resp;
  logic [2*REQ_W-1:0]  s_req;
  logic [2*RESP_W-1:0] s_resp;
  logic [2:0]        pend;
  logic              err;

  logic        m_ready, m_rvalid;
  logic [31:0] m_rdata;
  logic [1:0]  s_sav;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign m_req    = {avalid, addr, wdata, wstrb};
  assign s_resp   = {rd[1], rv[1], rdy[1], rd[0], rv[0], rdy[0]};
  assign m_ready  = m_resp[0];
  assign m_rvalid = m_resp[1];
  assign m_rdata  = m_resp[33:2];
  assign s_sav    = {s_req[2*REQ_W-1], s_req[REQ_W-1]};

  iob_dbus_split dut (
    .clk_i    (clk),
    .cke_i    (cke),
    .rst_i    (rst),
    .m_req_i  (m_req),
    .m_resp_o (m_resp),
    .s_req_o  (s_req),
    .s_resp_i (s_resp),
    .pend_o   (pend),
    .err_o    (err)
  );

  typedef struct {
    logic        av;
    logic [31:0] addr;
    logic [3:0]  wstrb;
    logic [1:0]  rdy, rv;
    logic [31:0] rd0, rd1;
    logic        e_rdy;
    logic [1:0]  e_sav;
    logic        e_rv;
    logic [31:0] e_rd;
    logic [2:0]  e_pend;
    logic        e_err;
  } vec_t;

  typedef struct {
    logic [31:0] data;
    int          due;
  } rsp_t;

  vec_t vt[$];
  logic [31:0] sb[$];
  rsp_t q0[$], q1[$];

  function automatic vec_t mkv(logic av, logic [31:0] a, logic [3:0] ws, logic [1:0] ry,
                               logic [1:0] v, logic [31:0] d0, logic [31:0] d1,
                               logic er, logic [1:0] es, logic ev, logic [31:0] ed,
                               logic [2:0] ep, logic ee);
    vec_t r;
    r.av = av; r.addr = a; r.wstrb = ws; r.rdy = ry; r.rv = v; r.rd0 = d0; r.rd1 = d1;
    r.e_rdy = er; r.e_sav = es; r.e_rv = ev; r.e_rd = ed; r.e_pend = ep; r.e_err = ee;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic set_in(input logic av, input logic [31:0] a, input logic [3:0] ws,
                        input logic [1:0] ry, input logic [1:0] v,
                        input logic [31:0] d0, input logic [31:0] d1);
    avalid = av; addr = a; wdata = ~a; wstrb = ws; rdy = ry; rv = v; rd[0] = d0; rd[1] = d1;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  localparam logic [31:0] A0 = 32'h0000_0100;
  localparam logic [31:0] A1 = 32'h8000_0004;
  localparam logic [31:0] B1 = 32'h8000_0000;

  initial begin
    int   cyc;
    logic took;

    cke = 1'b1; rst = 1'b1;
    set_in(0, 0, 0, 2'b11, 2'b00, 0, 0);
    repeat (2) next_cycle();
    rst = 1'b0;

    // av addr wstrb rdy rv rd0 rd1 | e_rdy e_sav e_rv e_rd e_pend e_err
    vt.push_back(mkv(0, 0,        0,    3, 0, 0,            0,            1, 0, 0, 0,            0, 0));
    vt.push_back(mkv(1, 32'h10,   4'hF, 3, 0, 0,            0,            1, 1, 0, 0,            0, 0));
    vt.push_back(mkv(0, 0,        0,    3, 0, 0,            0,            1, 0, 0, 0,            0, 0));
    vt.push_back(mkv(1, A1,       0,    3, 0, 0,            0,            1, 2, 0, 0,            0, 0));
    vt.push_back(mkv(0, 0,        0,    3, 0, 0,            0,            1, 0, 0, 0,            1, 0));
    vt.push_back(mkv(0, 0,        0,    3, 0, 0,            0,            1, 0, 0, 0,            1, 0));
    vt.push_back(mkv(0, 0,        0,    3, 2, 0,            32'hDEADBEEF, 1, 0, 1, 32'hDEADBEEF, 1, 0));
    vt.push_back(mkv(0, 0,        0,    3, 0, 0,            0,            1, 0, 0, 0,            0, 0));
    for (int i = 0; i < 4; i++)
      vt.push_back(mkv(1, A0,     0,    3, 0, 0,            0,            1, 1, 0, 0,            3'(i), 0));
    vt.push_back(mkv(1, A0,       0,    3, 0, 0,            0,            0, 0, 0, 0,            4, 0));
    vt.push_back(mkv(1, A0,       0,    3, 0, 0,            0,            0, 0, 0, 0,            4, 0));
    vt.push_back(mkv(1, A0,       0,    3, 1, 32'h11111111, 0,            1, 1, 1, 32'h11111111, 4, 0));
    vt.push_back(mkv(0, 0,        0,    3, 0, 0,            0,            1, 0, 0, 0,            4, 0));
    for (int i = 0; i < 4; i++)
      vt.push_back(mkv(0, 0,      0,    3, 1, 32'h22222222+i, 0,          1, 0, 1, 32'h22222222+i, 3'(4-i), 0));
    vt.push_back(mkv(0, 0,        0,    3, 0, 0,            0,            1, 0, 0, 0,            0, 0));
    vt.push_back(mkv(1, A0,       0,    3, 0, 0,            0,            1, 1, 0, 0,            0, 0));
    vt.push_back(mkv(1, B1,       0,    3, 0, 0,            0,            0, 0, 0, 0,            1, 0));
    vt.push_back(mkv(1, B1,       0,    3, 0, 0,            0,            0, 0, 0, 0,            1, 0));
    vt.push_back(mkv(1, B1,       0,    3, 1, 32'h33333333, 0,            1, 2, 1, 32'h33333333, 1, 0));
    vt.push_back(mkv(0, 0,        0,    3, 0, 0,            0,            1, 0, 0, 0,            1, 0));
    vt.push_back(mkv(0, 0,        0,    3, 2, 0,            32'h44444444, 1, 0, 1, 32'h44444444, 1, 0));
    vt.push_back(mkv(0, 0,        0,    3, 0, 0,            0,            1, 0, 0, 0,            0, 0));
    vt.push_back(mkv(1, A0,       0,    3, 0, 0,            0,            1, 1, 0, 0,            0, 0));
    vt.push_back(mkv(1, 32'h80000008, 4'h3, 3, 0, 0,        0,            1, 2, 0, 0,            1, 0));
    vt.push_back(mkv(0, 0,        0,    3, 1, 32'h55555555, 0,            1, 0, 1, 32'h55555555, 1, 0));
    vt.push_back(mkv(0, 0,        0,    3, 0, 0,            0,            1, 0, 0, 0,            0, 0));
    vt.push_back(mkv(1, A1,       0,    1, 0, 0,            0,            0, 2, 0, 0,            0, 0));
    vt.push_back(mkv(0, 0,        0,    3, 0, 0,            0,            1, 0, 0, 0,            0, 0));
    vt.push_back(mkv(0, 0,        0,    3, 2, 0,            32'h66666666, 1, 0, 0, 0,            0, 0));
    vt.push_back(mkv(0, 0,        0,    3, 0, 0,            0,            1, 0, 0, 0,            0, 1));
    vt.push_back(mkv(0, 0,        0,    3, 0, 0,            0,            1, 0, 0, 0,            0, 1));

    foreach (vt[i]) begin
      set_in(vt[i].av, vt[i].addr, vt[i].wstrb, vt[i].rdy, vt[i].rv, vt[i].rd0, vt[i].rd1);
      @(negedge clk);
      chk($sformatf("v%0d_ready", i), 32'(m_ready), 32'(vt[i].e_rdy));
      chk($sformatf("v%0d_savalid", i), 32'(s_sav), 32'(vt[i].e_sav));
      chk($sformatf("v%0d_rvalid", i), 32'(m_rvalid), 32'(vt[i].e_rv));
      if (vt[i].e_rv) chk($sformatf("v%0d_rdata", i), m_rdata, vt[i].e_rd);
      chk($sformatf("v%0d_pend", i), 32'(pend), 32'(vt[i].e_pend));
      chk($sformatf("v%0d_err", i), 32'(err), 32'(vt[i].e_err));
      chk($sformatf("v%0d_s1_addr", i), s_req[REQ_W+67 -: 32], vt[i].addr);
      chk($sformatf("v%0d_s0_wdata", i), s_req[35:4], ~vt[i].addr);
      $display("vec %0d: av=%0b addr=%h ready=%0b sav=%b rvalid=%0b pend=%0d err=%0b",
               i, vt[i].av, vt[i].addr, m_ready, s_sav, m_rvalid, pend, err);
      next_cycle();
    end

    // Reset with three reads outstanding and the error flag set
    for (int i = 0; i < 3; i++) begin
      set_in(1, A0, 0, 2'b11, 2'b00, 0, 0);
      next_cycle();
    end
    set_in(0, 0, 0, 2'b11, 2'b00, 0, 0);
    @(negedge clk);
    chk("pre_rst_pend", 32'(pend), 3);
    chk("pre_rst_err", 32'(err), 1);
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    set_in(1, A1, 0, 2'b11, 2'b00, 0, 0);
    @(negedge clk);
    chk("post_rst_pend", 32'(pend), 0);
    chk("post_rst_err", 32'(err), 0);
    chk("post_rst_ready", 32'(m_ready), 1);
    chk("post_rst_savalid", 32'(s_sav), 2);
    $display("rst seq: pend=%0d err=%0b ready=%0b", pend, err, m_ready);
    next_cycle();
    set_in(0, 0, 0, 2'b11, 2'b00, 0, 0);
    @(negedge clk);
    chk("post_rst_acc_pend", 32'(pend), 1);

    // Clock enable low: response visible combinationally but not counted
    next_cycle();
    cke = 1'b0;
    set_in(0, 0, 0, 2'b11, 2'b10, 0, 32'h77777777);
    @(negedge clk);
    chk("cke0_rvalid", 32'(m_rvalid), 1);
    chk("cke0_rdata", m_rdata, 32'h77777777);
    next_cycle();
    @(negedge clk);
    chk("cke0_pend_hold", 32'(pend), 1);
    next_cycle();
    cke = 1'b1;
    next_cycle();
    set_in(0, 0, 0, 2'b11, 2'b00, 0, 0);
    @(negedge clk);
    chk("cke1_pend", 32'(pend), 0);
    chk("cke1_err", 32'(err), 0);
    $display("cke seq: pend=%0d err=%0b", pend, err);
    next_cycle();

    // Randomised reads/writes against a latency slave model with a scoreboard
    cyc = 0;
    took = 1'b0;
    avalid = 1'b0;
    for (int n = 0; n < 600; n++) begin
      if (!avalid || took) begin
        avalid = (n < 300) && ($urandom_range(0, 4) != 0);
        addr   = ({31'd0, 1'($urandom_range(0, 1))} << 31) | ($urandom & 32'h0000_FFFC);
        wdata  = $urandom;
        wstrb  = ($urandom_range(0, 3) == 0) ? 4'hF : 4'h0;
      end
      rdy[0] = ($urandom_range(0, 3) != 0);
      rdy[1] = ($urandom_range(0, 3) != 0);
      rv[0]  = (q0.size() != 0) && (q0[0].due <= cyc);
      rv[1]  = (q1.size() != 0) && (q1[0].due <= cyc);
      rd[0]  = rv[0] ? q0[0].data : $urandom;
      rd[1]  = rv[1] ? q1[0].data : $urandom;
      @(negedge clk);
      if (m_rvalid) begin
        if (sb.size() == 0) begin
          chk("sb_unexpected_rvalid", 32'(m_rvalid), 0);
        end else begin
          logic [31:0] exp_d;
          exp_d = sb.pop_front();
          chk("sb_rdata", m_rdata, exp_d);
          $display("sb rd: got %h exp %h", m_rdata, exp_d);
        end
      end
      took = avalid && m_ready;
      if (took && (wstrb == 4'h0)) begin
        rsp_t r;
        r.data = addr ^ KEY;
        r.due  = cyc + 1 + int'($urandom_range(0, 2));
        sb.push_back(addr ^ KEY);
        if (addr[31]) begin
          if (q1.size() != 0 && q1[$].due > r.due) r.due = q1[$].due;
          q1.push_back(r);
        end else begin
          if (q0.size() != 0 && q0[$].due > r.due) r.due = q0[$].due;
          q0.push_back(r);
        end
      end
      if (rv[0]) void'(q0.pop_front());
      if (rv[1]) void'(q1.pop_front());
      next_cycle();
      cyc++;
      chk("sb_pend_track", 32'(pend), 32'(sb.size()));
      if (n >= 300 && !avalid && sb.size() == 0 && q0.size() == 0 && q1.size() == 0) break;
    end
    chk("sb_drained", 32'(sb.size()), 0);
    chk("sb_err_clear", 32'(err), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
